// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction fetch response block: CPU stage
// encoding, opcode map, default NOP word, fetch FSM states and the BNEQ
// offset helper used at execute time.
package inst_fetch_resp_pkg;

  // One-hot stage vector from the stage sequencer
  localparam int STAT_W  = 4;
  localparam int STAT_IF = 0;
  localparam int STAT_ID = 1;
  localparam int STAT_EX = 2;
  localparam int STAT_WB = 3;

  // Opcode map held in ir[15:12]
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNEQ = 4'hB,
    OP_JMP  = 4'hC
  } opcode_e;

  // Word loaded into ir at reset and when a fetch times out
  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  // Branch offset for the PC adder: low byte of a BNEQ whose compare was non-zero
  function automatic logic [7:0] bneq_offset(input logic [15:0] ir_word,
                                             input logic [3:0]  opc_bneq,
                                             input logic        zero);
    logic [7:0] off;
    if ((ir_word[15:12] == opc_bneq) && (zero == 1'b0)) begin
      off = ir_word[7:0];
    end else begin
      off = 8'h00;
    end
    return off;
  endfunction

endpackage

// File: rtl/inst_fetch_resp_fetch_timer.sv
// Response timeout counter. Clear forces the count to zero; every enabled
// cycle counts up. Expired is raised during the TIMEOUT-th enabled cycle
// after a clear, i.e. the last cycle a response may still arrive in.
module fetch_timer
  import inst_fetch_resp_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             at_limit_s;

  assign at_limit_s = (cnt_q == LIMIT);
  assign expired    = enable & at_limit_s;

  // Next count: clear wins, then count while enabled, holding at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && !at_limit_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction fetch response block. On IF entry it issues a single read
// strobe, waits for the memory response (bounded by TIMEOUT), loads ir and
// pulses ir_valid. A timeout loads NOP_WORD and sets the sticky fetch_err.
// During EX it registers the BNEQ branch offset for the PC adder.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF,
  parameter logic [3:0]  OPC_BNEQ = OP_BNEQ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAT_W-1:0] stat,
  input  logic [15:0]       inst_addr,
  input  logic              zero_flag,
  output logic              mem_en,
  output logic [15:0]       mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       ir,
  output logic              ir_valid,
  output logic              fetch_stall,
  output logic              fetch_err,
  output logic [7:0]        imm_bneq
);

  fetch_state_e state_d;
  fetch_state_e state_q;

  logic        mem_en_d,      mem_en_q;
  logic [15:0] mem_addr_d,    mem_addr_q;
  logic [15:0] ir_d,          ir_q;
  logic        ir_valid_d,    ir_valid_q;
  logic        fetch_stall_d, fetch_stall_q;
  logic        fetch_err_d,   fetch_err_q;
  logic [7:0]  imm_bneq_d,    imm_bneq_q;

  logic tmr_clear_s;
  logic tmr_en_s;
  logic tmr_expired_s;

  // ID and WB are part of the stage vector but do not affect fetch
  logic unused_stat_s;
  assign unused_stat_s = stat[STAT_ID] ^ stat[STAT_WB];

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one request per IF phase, response or timeout ends the wait
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stat[STAT_IF]) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid || tmr_expired_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (!stat[STAT_IF]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: next values of the registered outputs and timer controls
  always_comb begin
    mem_en_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    ir_d          = ir_q;
    ir_valid_d    = 1'b0;
    fetch_stall_d = fetch_stall_q;
    fetch_err_d   = fetch_err_q;
    imm_bneq_d    = imm_bneq_q;
    tmr_clear_s   = 1'b0;
    tmr_en_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stat[STAT_IF]) begin
          mem_en_d      = 1'b1;
          mem_addr_d    = inst_addr;
          fetch_stall_d = 1'b1;
          imm_bneq_d    = 8'h00;
        end else begin
          fetch_stall_d = 1'b0;
        end
      end
      ST_REQ: begin
        // Zero the counter so the first WAIT cycle starts at count 0
        tmr_clear_s   = 1'b1;
        fetch_stall_d = 1'b1;
      end
      ST_WAIT: begin
        tmr_en_s = 1'b1;
        // A response in the timeout cycle still counts as a good fetch
        if (mem_rvalid) begin
          ir_d          = mem_rdata;
          ir_valid_d    = 1'b1;
          fetch_stall_d = 1'b0;
        end else if (tmr_expired_s) begin
          ir_d          = NOP_WORD;
          ir_valid_d    = 1'b1;
          fetch_stall_d = 1'b0;
          fetch_err_d   = 1'b1;
        end else begin
          fetch_stall_d = 1'b1;
        end
      end
      ST_DONE: begin
        fetch_stall_d = 1'b0;
      end
      default: begin
        fetch_stall_d = 1'b0;
      end
    endcase
    // Branch offset is sampled whenever the execute stage is active
    if (stat[STAT_EX]) begin
      imm_bneq_d = bneq_offset(ir_q, OPC_BNEQ, zero_flag);
    end else begin
      imm_bneq_d = imm_bneq_d;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q      <= 1'b0;
      mem_addr_q    <= 16'h0000;
      ir_q          <= NOP_WORD;
      ir_valid_q    <= 1'b0;
      fetch_stall_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      imm_bneq_q    <= 8'h00;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_stall_q <= fetch_stall_d;
      fetch_err_q   <= fetch_err_d;
      imm_bneq_q    <= imm_bneq_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_stall = fetch_stall_q;
  assign fetch_err   = fetch_err_q;
  assign imm_bneq    = imm_bneq_q;

endmodule
